// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if
// Bundles the command/response port and the AHB-Lite bus of ahb_lite_master.
//
// Handshake rules:
//   cmd_* : a command transfers on a rising HCLK edge where
//           cmd_valid && cmd_ready. The command fields must be stable while
//           cmd_valid is high. cmd_ready never depends on cmd_valid.
//   rsp_* : rsp_valid is a single-cycle pulse with no backpressure. There is
//           exactly one response per accepted command, in command order.
//
// Modports:
//   master : view of the bridge (drives cmd_ready, rsp_*, AHB address/control/wdata)
//   slave  : view of the surrounding logic (drives cmd_*, HRDATA, HREADY, HRESP)
interface ahb_lite_master_if #(
  parameter int AW = 32
);
  // command port
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_size;
  logic [31:0]   cmd_wdata;
  // response port
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  // AHB-Lite bus
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADY;
  logic          HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_master.sv
// ahb_lite_master
// Single-transfer AHB-Lite master: turns valid/ready commands into NONSEQ
// SINGLE transfers and returns read data / error status as a response pulse.
//
// Ports:
//   HCLK     clock
//   HRESETn  asynchronous, active-low reset
//   bus      ahb_lite_master_if.master: cmd_* in, rsp_* out, AHB-Lite bus
//
// Configuration:
//   AHB_MST_PIPE_EN  defined   : address and data phases overlap, so
//                                back-to-back commands issue with no idle cycle.
//                    undefined : one transfer in flight at a time.
//
// Structure: an address stage (AP) driving HADDR/HTRANS/HWRITE/HSIZE and a
// data stage (DP) driving HWDATA and capturing the response. A two-cycle
// ERROR response sets err_hold, which parks a pending AP as IDLE until the
// erroring transfer completes; the parked command is then reissued.
module ahb_lite_master #(
  parameter int AW = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_lite_master_if.master bus
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // address stage
  logic          ap_valid_q, ap_valid_d;
  logic [1:0]    htrans_q, htrans_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic          hwrite_q, hwrite_d;
  logic [2:0]    hsize_q, hsize_d;
  logic [31:0]   ap_wdata_q, ap_wdata_d;
  // data stage
  logic          dp_valid_q, dp_valid_d;
  logic          dp_write_q, dp_write_d;
  logic [1:0]    dp_size_q, dp_size_d;
  logic [1:0]    dp_lane_q, dp_lane_d;
  logic [31:0]   hwdata_q, hwdata_d;
  logic          err_hold_q, err_hold_d;
  // response
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic          cmd_ready_int;
  logic          cmd_fire;
  logic          ap_adv;
  logic          dp_done;
  logic [1:0]    size_norm;
  logic [AW-1:0] addr_aligned;
  logic [31:0]   wdata_rep;
  logic [31:0]   rdata_lane;

`ifdef AHB_MST_PIPE_EN
  assign cmd_ready_int = !err_hold_q && (!ap_valid_q || bus.HREADY);
`else
  assign cmd_ready_int = !ap_valid_q && !dp_valid_q && !err_hold_q;
`endif

  assign cmd_fire = bus.cmd_valid && cmd_ready_int;
  // An AP only completes while it is actually driven as NONSEQ; a parked
  // (IDLE) AP must not slip into the data stage on the error's HREADY edge.
  assign ap_adv   = ap_valid_q && (htrans_q == HTRANS_NONSEQ) && bus.HREADY;
  assign dp_done  = dp_valid_q && bus.HREADY;

  // Command decode: size 3 behaves as a word; address low bits cleared to
  // the transfer size; write data replicated across byte lanes.
  always_comb begin
    size_norm = (bus.cmd_size == 2'd3) ? 2'd2 : bus.cmd_size;
    case (size_norm)
      2'd0: begin
        addr_aligned = bus.cmd_addr;
        wdata_rep    = {4{bus.cmd_wdata[7:0]}};
      end
      2'd1: begin
        addr_aligned = {bus.cmd_addr[AW-1:1], 1'b0};
        wdata_rep    = {2{bus.cmd_wdata[15:0]}};
      end
      default: begin
        addr_aligned = {bus.cmd_addr[AW-1:2], 2'b00};
        wdata_rep    = bus.cmd_wdata;
      end
    endcase
  end

  // Read lane extraction using the address captured into the data stage.
  always_comb begin
    case (dp_size_q)
      2'd0:    rdata_lane = {24'd0, bus.HRDATA[{dp_lane_q, 3'b000} +: 8]};
      2'd1:    rdata_lane = dp_lane_q[1] ? {16'd0, bus.HRDATA[31:16]}
                                         : {16'd0, bus.HRDATA[15:0]};
      default: rdata_lane = bus.HRDATA;
    endcase
  end

  always_comb begin
    ap_valid_d  = ap_valid_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    dp_size_d   = dp_size_q;
    dp_lane_d   = dp_lane_q;
    hwdata_d    = hwdata_q;
    err_hold_d  = err_hold_q;
    htrans_d    = HTRANS_IDLE;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    // Address stage: drain on completion, refill from an accepted command
    // (both can happen on the same edge for back-to-back issue).
    if (ap_adv) ap_valid_d = 1'b0;
    if (cmd_fire) begin
      ap_valid_d = 1'b1;
      haddr_d    = addr_aligned;
      hwrite_d   = bus.cmd_write;
      hsize_d    = {1'b0, size_norm};
      ap_wdata_d = wdata_rep;
    end

    // Data stage
    if (dp_done) dp_valid_d = 1'b0;
    if (ap_adv) begin
      dp_valid_d = 1'b1;
      dp_write_d = hwrite_q;
      dp_size_d  = hsize_q[1:0];
      dp_lane_d  = haddr_q[1:0];
      if (hwrite_q) hwdata_d = ap_wdata_q;
    end

    // err_hold covers the second ERROR cycle only: set by the first cycle
    // (HRESP=1, HREADY=0), released when the data stage completes.
    if (err_hold_q) err_hold_d = !dp_done;
    else            err_hold_d = dp_valid_q && bus.HRESP && !bus.HREADY;

    // A pending AP is shown as IDLE while err_hold is set, then re-driven.
    if (ap_valid_d && !err_hold_d) htrans_d = HTRANS_NONSEQ;

    if (dp_done) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = bus.HRESP;
      if (!dp_write_q) rsp_rdata_d = rdata_lane;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ap_valid_q  <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= 3'b000;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_size_q   <= 2'b00;
      dp_lane_q   <= 2'b00;
      hwdata_q    <= '0;
      err_hold_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      ap_valid_q  <= ap_valid_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      dp_size_q   <= dp_size_d;
      dp_lane_q   <= dp_lane_d;
      hwdata_q    <= hwdata_d;
      err_hold_q  <= err_hold_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HBURST    = 3'b000;
  assign bus.HPROT     = 4'b0011;
  assign bus.HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master
// Directed bench for ahb_lite_master. A reactive AHB slave model checks each
// address phase and the write data; a response monitor checks rsp_* against
// an expected queue filled by the command driver.
module tb_ahb_lite_master;
  localparam int AW  = 32;
  localparam int APW = AW + 1 + 3 + 32;

`ifdef AHB_MST_PIPE_EN
  localparam int GAP_B2B  = 1;
  localparam int GAP_WAIT = 3;
  localparam int GAP_ERR  = 2;
`else
  localparam int GAP_B2B  = 3;
  localparam int GAP_WAIT = 5;
  localparam int GAP_ERR  = 3;
`endif

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_lite_master_if #(.AW(AW)) bus ();
  ahb_lite_master #(.AW(AW)) dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

  int cyc = 0;
  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0]    exp_q[$];   // {rsp_err, rsp_rdata}
  logic [APW-1:0] ap_q[$];    // {HADDR, HWRITE, HSIZE, HWDATA}
  int             rsp_cyc_q[$];
  int             last_acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0]   sl_mem [4];
  int            sl_waits = 0;
  logic          sl_err_en = 1'b0;
  logic [AW-1:0] sl_err_addr = '0;
  logic          sl_dp, sl_dp_wr;
  logic [AW-1:0] sl_dp_addr;
  logic [31:0]   sl_dp_wdata;
  int            sl_cnt, sl_errph;
  logic          prev_ready;
  logic [1:0]    prev_htrans;
  logic [AW-1:0] prev_addr;
  logic          prev_write;
  logic [2:0]    prev_size;

  initial begin
    logic [APW-1:0] e;
    sl_mem[0] = 32'hDEAD_0001;
    sl_mem[1] = 32'h1122_3344;
    sl_mem[2] = 32'hCAFE_F00D;
    sl_mem[3] = 32'h0BAD_BEEF;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = '0;
    sl_dp = 1'b0; sl_dp_wr = 1'b0; sl_dp_addr = '0; sl_dp_wdata = '0;
    sl_cnt = 0; sl_errph = 0;
    prev_ready = 1'b1; prev_htrans = 2'b00; prev_addr = '0; prev_write = 1'b0; prev_size = '0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        sl_dp = 1'b0; sl_errph = 0; sl_cnt = 0;
        prev_htrans = 2'b00; prev_ready = 1'b1;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
      end else begin
        // retire the data phase that completed on the last edge
        if (sl_dp && prev_ready) sl_dp = 1'b0;
        // address phase accepted on the last edge
        if (prev_htrans == 2'b10 && prev_ready) begin
          if (ap_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL ap_unexpected: actual address phase at %0h, required none", prev_addr);
          end else begin
            e = ap_q.pop_front();
            check("ap_haddr", prev_addr, e[APW-1 -: AW]);
            check("ap_hwrite", prev_write, e[35]);
            check("ap_hsize", prev_size, e[34:32]);
            sl_dp = 1'b1; sl_dp_wr = prev_write; sl_dp_addr = prev_addr;
            sl_dp_wdata = e[31:0];
            sl_cnt = sl_waits;
            sl_errph = (sl_err_en && prev_addr == sl_err_addr) ? 2 : 0;
            if (sl_errph != 0) sl_err_en = 1'b0;
          end
        end
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = '0;
        if (sl_dp) begin
          if (sl_dp_wr) check("hwdata", bus.HWDATA, sl_dp_wdata);
          if (sl_cnt > 0) begin
            bus.HREADY = 1'b0;
            sl_cnt--;
          end else if (sl_errph == 2) begin
            bus.HREADY = 1'b0; bus.HRESP = 1'b1; sl_errph = 1;
          end else if (sl_errph == 1) begin
            bus.HRESP = 1'b1; sl_errph = 0;
            check("htrans_err2", bus.HTRANS, 2'b00);
          end else if (!sl_dp_wr) begin
            bus.HRDATA = sl_mem[sl_dp_addr[3:2]];
          end
        end
        prev_ready = bus.HREADY; prev_htrans = bus.HTRANS; prev_addr = bus.HADDR;
        prev_write = bus.HWRITE; prev_size = bus.HSIZE;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: actual rsp_valid=1 rdata %0h, required no response", bus.rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          check("rsp_err", bus.rsp_err, e[32]);
          check("rsp_rdata", bus.rsp_rdata, e[31:0]);
          rsp_cyc_q.push_back(cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input logic [AW-1:0] exp_addr,
                       input logic [2:0] exp_size, input logic [31:0] exp_hwdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    logic fired = 1'b0;
    int guard = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_size = size; bus.cmd_wdata = wdata;
    while (!fired && guard < 100) begin
      @(negedge HCLK); #1;
      fired = bus.cmd_ready;
      if (fired) begin
        last_acc_cyc = cyc;
        ap_q.push_back({exp_addr, wr, exp_size, exp_hwdata});
        exp_q.push_back({exp_err, exp_rdata});
      end
      @(posedge HCLK); #1;
      guard++;
    end
    bus.cmd_valid = 1'b0;
    if (!fired) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: actual not accepted after %0d cycles, required accept", guard);
    end
  endtask

  task automatic drain(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || ap_q.size() != 0) && g < 100) begin
      @(negedge HCLK);
      g++;
    end
    checks++;
    if (exp_q.size() != 0 || ap_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: actual %0d responses outstanding, required 0", name, exp_q.size());
    end
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  task automatic check_gaps(input string name, input int gap);
    if (rsp_cyc_q.size() < 2) begin
      checks++; errors++;
      $display("FAIL %s: actual %0d responses, required at least 2", name, rsp_cyc_q.size());
    end else begin
      for (int i = 1; i < rsp_cyc_q.size(); i++)
        check(name, rsp_cyc_q[i] - rsp_cyc_q[i-1], gap);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_size = 2'd0; bus.cmd_wdata = '0;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_htrans", bus.HTRANS, 2'b00);
    check("rst_haddr", bus.HADDR, 0);
    check("rst_hwrite", bus.HWRITE, 0);
    check("rst_hsize", bus.HSIZE, 0);
    check("rst_hwdata", bus.HWDATA, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("hburst", bus.HBURST, 3'b000);
    check("hprot", bus.HPROT, 4'b0011);
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;

    // word write, latency from accept edge to response
    rsp_cyc_q.delete();
    issue(1'b1, 32'h4, 2'd2, 32'hA5A5_1234, 32'h4, 3'b010, 32'hA5A5_1234, 32'h0, 1'b0);
    drain("wr_word");
    if (rsp_cyc_q.size() == 1) check("wr_word_latency", rsp_cyc_q[0] - last_acc_cyc, 3);
    else check("wr_word_rsp_count", rsp_cyc_q.size(), 1);

    // byte read, lane 2 of 0x11223344
    issue(1'b0, 32'h6, 2'd0, 32'h0, 32'h6, 3'b000, 32'h0, 32'h0000_0022, 1'b0);
    drain("rd_byte");
    // halfword write, lane-replicated
    issue(1'b1, 32'hA, 2'd1, 32'h0000_BEEF, 32'hA, 3'b001, 32'hBEEF_BEEF, 32'h0, 1'b0);
    drain("wr_half");
    // byte write replicated to all lanes
    issue(1'b1, 32'h3, 2'd0, 32'h1234_565A, 32'h3, 3'b000, 32'h5A5A_5A5A, 32'h0, 1'b0);
    drain("wr_byte");
    // size 3 issued as word, unaligned address cleared to 0x4
    issue(1'b1, 32'h7, 2'd3, 32'hCAFE_BABE, 32'h4, 3'b010, 32'hCAFE_BABE, 32'h0, 1'b0);
    drain("wr_size3");
    // halfword read upper lane of 0x0BADBEEF
    issue(1'b0, 32'hE, 2'd1, 32'h0, 32'hE, 3'b001, 32'h0, 32'h0000_0BAD, 1'b0);
    drain("rd_half_hi");
    // halfword read at odd address: aligned to 0x4, lower lane
    issue(1'b0, 32'h5, 2'd1, 32'h0, 32'h4, 3'b001, 32'h0, 32'h0000_3344, 1'b0);
    drain("rd_half_lo");
    // word read at 0x9 aligned to 0x8
    issue(1'b0, 32'h9, 2'd2, 32'h0, 32'h8, 3'b010, 32'h0, 32'hCAFE_F00D, 1'b0);
    drain("rd_word");

    // three back-to-back word reads
    rsp_cyc_q.delete();
    issue(1'b0, 32'h0, 2'd2, 32'h0, 32'h0, 3'b010, 32'h0, 32'hDEAD_0001, 1'b0);
    issue(1'b0, 32'h4, 2'd2, 32'h0, 32'h4, 3'b010, 32'h0, 32'h1122_3344, 1'b0);
    issue(1'b0, 32'h8, 2'd2, 32'h0, 32'h8, 3'b010, 32'h0, 32'hCAFE_F00D, 1'b0);
    drain("b2b");
    check_gaps("b2b_gap", GAP_B2B);

    // two wait states per data phase: write followed by a read
    rsp_cyc_q.delete();
    sl_waits = 2;
    issue(1'b1, 32'h10, 2'd2, 32'h0F0F_0F0F, 32'h10, 3'b010, 32'h0F0F_0F0F, 32'h0, 1'b0);
    issue(1'b0, 32'h4, 2'd2, 32'h0, 32'h4, 3'b010, 32'h0, 32'h1122_3344, 1'b0);
    drain("wait");
    check_gaps("wait_gap", GAP_WAIT);
    sl_waits = 0;

    // ERROR on read 0x0 with read 0x4 following; 0x4 must be reissued
    rsp_cyc_q.delete();
    sl_err_addr = 32'h0;
    sl_err_en = 1'b1;
    issue(1'b0, 32'h0, 2'd2, 32'h0, 32'h0, 3'b010, 32'h0, 32'h0, 1'b1);
    issue(1'b0, 32'h4, 2'd2, 32'h0, 32'h4, 3'b010, 32'h0, 32'h1122_3344, 1'b0);
    drain("err");
    check_gaps("err_gap", GAP_ERR);

    // reset while an address phase is on the bus
    issue(1'b1, 32'h20, 2'd2, 32'h0000_0077, 32'h20, 3'b010, 32'h0000_0077, 32'h0, 1'b0);
    check("midrst_pre_htrans", bus.HTRANS, 2'b10);
    HRESETn = 1'b0;
    #1;
    check("midrst_htrans", bus.HTRANS, 2'b00);
    check("midrst_haddr", bus.HADDR, 0);
    check("midrst_hwdata", bus.HWDATA, 0);
    exp_q.delete();
    ap_q.delete();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    // recovery: byte read lane 3 of 0xDEAD0001
    issue(1'b0, 32'h3, 2'd0, 32'h0, 32'h3, 3'b000, 32'h0, 32'h0000_00DE, 1'b0);
    drain("recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: actual time limit reached, required end of stimulus");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-transfer AHB-Lite master. Converts a simple valid/ready command port into AHB NONSEQ SINGLE transfers; returns read data and error status on a response port.
- Sits between firmware/DMA-style control logic and the AHB-Lite fabric; drives config-register slaves on that fabric.
- Address and data phases are pipelined, so back-to-back commands issue with no idle cycle.

Parameters:
- AW, 32, HADDR and cmd_addr width.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AW  byte address
- cmd_size  in  2  0=byte, 1=halfword, 2/3=word
- cmd_wdata  in  32  write data, right-justified
- rsp_valid  out  1  one-cycle response pulse; sink has no backpressure
- rsp_rdata  out  32  read data, right-justified and zero-extended; 0 for writes
- rsp_err  out  1  transfer ended with HRESP=ERROR
- HADDR  out  AW  AHB address
- HTRANS  out  2  IDLE (00) / NONSEQ (10)
- HWRITE  out  1  AHB write
- HSIZE  out  3  AHB size
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  constant 4'b0011
- HWDATA  out  32  AHB write data
- HRDATA  in  32  AHB read data
- HREADY  in  1  bus ready
- HRESP  in  1  bus error

Behaviour:
- Clock HCLK; reset HRESETn, asynchronous, active-low.
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. cmd_ready=1 when leaving reset.
- All AHB outputs are registered.
- Address stage (AP):
  - An accepted command loads AP on the next edge: HTRANS=NONSEQ.
  - HSIZE = {1'b0, cmd_size}; cmd_size 3 is issued as 3'b010.
  - HADDR = cmd_addr with low bits cleared per size (byte: none; halfword: [0]; word: [1:0]).
  - AP holds until an edge with HREADY=1. At that edge AP moves to the data stage (DP).
  - If no new command is accepted at that edge, HTRANS becomes IDLE.
- Data stage (DP):
  - Write data is lane-replicated and placed on HWDATA at the AP→DP edge: byte {4{wdata[7:0]}}, halfword {2{wdata[15:0]}}, word as-is.
  - HWDATA is held until DP completes.
- DP completion: first edge with HREADY=1 while DP is valid.
  - Next cycle: rsp_valid=1.
  - rsp_err = HRESP sampled at that edge.
  - rsp_rdata for reads = HRDATA lane selected by captured HADDR[1:0] and size, zero-extended. Halfword uses HADDR[1].
- cmd_ready = !err_hold & (!AP_valid | HREADY). A command accepted while AP completes loads AP in the same edge, giving back-to-back NONSEQ.
- Error (two-cycle HRESP):
  - First error cycle (HRESP=1, HREADY=0, DP valid) → set err_hold.
  - If AP is valid, HTRANS=IDLE on the next edge while HADDR/HSIZE/HWRITE are retained.
  - The second cycle (HREADY=1) completes DP with rsp_err=1.
  - err_hold clears at that edge. The retained AP re-drives NONSEQ the cycle after and is reissued, not dropped.
  - cmd_ready=0 while err_hold is set.
- Responses return strictly in command order, with exactly one rsp_valid per accepted command.
- Reset mid-transfer: all stages cleared, no response for in-flight commands, HTRANS=IDLE immediately.

Optional Feature:
- Macro AHB_MST_PIPE_EN.
- Defined: pipelined behaviour as above.
- Undefined: non-pipelined. cmd_ready = !AP_valid & !DP_valid & !err_hold, so at most one transfer is in flight and an IDLE cycle follows each transfer. The error cancel path is unused.

Test Plan:
- Write word 0x0000_0004, data 0xA5A5_1234, HREADY=1 → HTRANS=10, HADDR=0x4, HSIZE=010 for 1 cycle; HWDATA=0xA5A5_1234 next cycle; rsp_valid=1, rsp_err=0 the following cycle.
- Read byte 0x0000_0006, slave HRDATA=0x11223344 → HADDR=0x6, HSIZE=000, rsp_rdata=0x0000_0022.
- Write halfword 0x0000_000A, data 0x0000_BEEF → HADDR=0xA, HWDATA=0xBEEF_BEEF, HSIZE=001.
- Three back-to-back reads at 0x0/0x4/0x8, HREADY=1 (PIPE_EN) → NONSEQ on 3 consecutive cycles, 3 consecutive rsp_valid pulses in order.
- Slave inserts 2 wait states on a write → HWDATA stable for 3 cycles, next AP held, single rsp_valid after the HREADY=1 edge.
- Error on read at 0x0 with pending read at 0x4 → HTRANS=IDLE in second error cycle, rsp_err=1 for 0x0, then 0x4 reissued and completes with rsp_err=0.
